// File: rtl/ysyx_22041071_ifu_axi_pkg.sv
// Shared AXI read-master definitions for the fetch and data-side masters:
// FSM state encodings, burst/response codes, size and len widths.
package ysyx_22041071_ifu_axi_pkg;

    // Master FSM states, shared encoding with the data-side master.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_OUT  = 2'd3
    } ifu_state_e;

    // AXI burst type used for all fetches.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI response codes.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Size code for a full 64-bit doubleword transfer.
    localparam logic [2:0] SIZE_D = 3'b011;

    // Width of the AXI len field.
    localparam int AXI_LEN_W = 8;

    // The PC stage hands over a 2-bit size code; AXI wants 3 bits.
    function automatic logic [2:0] axi_size(input logic [1:0] s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/ysyx_22041071_ifu_axi_rbuf.sv
// Read buffer for the fetch master: captures the first R beat of a burst,
// selects the 32-bit instruction half for the fetched PC and holds the
// result (instruction + error flag) stable while it is presented to decode.
module ysyx_22041071_ifu_axi_rbuf
    import ysyx_22041071_ifu_axi_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,     // AR handshake: a new burst begins
    input  logic              beat_i,      // R handshake
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              bus_err_i,   // rresp[1] of the current beat
    input  logic              sel_hi_i,    // pc[2]: upper word of the doubleword
    input  logic              misalign_i,  // pc[1:0] != 0
    output logic [31:0]       inst_o,
    output logic              err_o
);

    logic        first_q, first_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;

    // Only the first beat of a burst carries the instruction; later beats
    // are drained without touching the hold register.
    always_comb begin
        first_d = first_q;
        inst_d  = inst_q;
        err_d   = err_q;
        if (start_i) begin
            first_d = 1'b1;
        end else if (beat_i) begin
            first_d = 1'b0;
        end
        if (beat_i && first_q) begin
            inst_d = sel_hi_i ? rdata_i[63:32] : rdata_i[31:0];
            err_d  = bus_err_i | misalign_i;
        end
    end

    // Capture/hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            first_q <= first_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign inst_o = inst_q;
    assign err_o  = err_q;

endmodule

// File: rtl/ysyx_22041071_ifu_axi.sv
// Instruction-fetch AXI4 read master. Takes one fetch request from the PC
// stage, issues it on AR, collects the R burst and hands {pc, inst, err}
// to decode. One outstanding transaction; a redirect flush drops the
// in-flight or held fetch.
// Optional: define YSYX_22041071_IFU_PERF_EN to add performance counters.
module ysyx_22041071_ifu_axi
    import ysyx_22041071_ifu_axi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // PC stage
    input  logic                 req_valid,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [AXI_LEN_W-1:0] req_len,
    input  logic [1:0]           req_size,
    output logic                 req_ready,
    input  logic                 flush,
    // AXI AR channel
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    output logic [ADDR_W-1:0]    axi_araddr,
    output logic [ID_W-1:0]      axi_arid,
    output logic [AXI_LEN_W-1:0] axi_arlen,
    output logic [2:0]           axi_arsize,
    output logic [1:0]           axi_arburst,
    // AXI R channel
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic [DATA_W-1:0]    axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rlast,
    input  logic [ID_W-1:0]      axi_rid,
    // Decode
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [ADDR_W-1:0]    inst_pc,
    output logic [31:0]          inst,
    output logic                 inst_err
`ifdef YSYX_22041071_IFU_PERF_EN
    ,
    output logic [63:0]          perf_fetch_cnt,
    output logic [63:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    ifu_state_e           state_q, state_d;
    logic                 drop_q, drop_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [AXI_LEN_W-1:0] len_q;
    logic [1:0]           size_q;

    logic req_acc;
    logic ar_fire;
    logic r_fire;

    assign req_acc = req_valid && req_ready;
    assign ar_fire = axi_arvalid && axi_arready;
    assign r_fire  = axi_rvalid && axi_rready;

    // Next-state and handshake outputs. A request is never taken in a
    // flush cycle, and a flush anywhere in AR/R marks the burst for drop
    // so its data is drained on AXI but never shown to decode.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_ready   = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        inst_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) state_d = ST_AR;
            end
            ST_AR: begin
                axi_arvalid = 1'b1;
                if (flush)       drop_d  = 1'b1;
                if (axi_arready) state_d = ST_R;
            end
            ST_R: begin
                axi_rready = 1'b1;
                if (flush) drop_d = 1'b1;
                if (axi_rvalid && axi_rlast) begin
                    state_d = (drop_q || flush) ? ST_IDLE : ST_OUT;
                    drop_d  = 1'b0;
                end
            end
            ST_OUT: begin
                inst_valid = 1'b1;
                req_ready  = inst_ready && !flush;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (inst_ready) begin
                    state_d = req_valid ? ST_AR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Request fields, latched on accept and held through AR until the
    // next accept; addr_q doubles as the PC reported to decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
        end else if (req_acc) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            size_q <= req_size;
        end
    end

    assign axi_araddr  = addr_q;
    assign axi_arid    = ID_W'(AXI_ID);
    assign axi_arlen   = len_q;
    assign axi_arsize  = axi_size(size_q);
    assign axi_arburst = AXI_BURST_INCR;

    ysyx_22041071_ifu_axi_rbuf #(
        .DATA_W (DATA_W)
    ) u_rbuf (
        .clk        (clk),
        .rst_n      (reset_n),
        .start_i    (ar_fire),
        .beat_i     (r_fire),
        .rdata_i    (axi_rdata),
        .bus_err_i  (axi_rresp[1]),
        .sel_hi_i   (addr_q[2]),
        .misalign_i (addr_q[1:0] != 2'b00),
        .inst_o     (inst),
        .err_o      (inst_err)
    );

    assign inst_pc = addr_q;

    // rid is not checked (single outstanding fetch); resp[0] does not
    // distinguish error from okay for our purposes.
    logic unused_rfields;
    assign unused_rfields = ^{axi_rid, axi_rresp[0]};

`ifdef YSYX_22041071_IFU_PERF_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Free-running wrap-around counters: delivered fetches, cycles waiting
    // on the bus, and flushes that hit a busy master.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (inst_valid && inst_ready)
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            if (state_q == ST_AR || state_q == ST_R)
                stall_cnt_q <= stall_cnt_q + 64'd1;
            if (flush && state_q != ST_IDLE)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22041071_ifu_axi.sv
// Bench for the fetch AXI master: directed scenarios followed by a random
// run, with a bench-side AXI slave (hashed memory) and a transaction-level
// reference model of which fetch must reach decode and with what value.
module tb_ysyx_22041071_ifu_axi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [1:0]  req_size = 2'd2;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        axi_arvalid;
    logic        axi_arready = 1'b0;
    logic [63:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;
    logic [63:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0;
    logic        axi_rlast = 1'b0;
    logic [3:0]  axi_rid = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [63:0] inst_pc;
    logic [31:0] inst;
    logic        inst_err;

    always #5 clk = ~clk;

    ysyx_22041071_ifu_axi dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_ready(req_ready), .flush(flush),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rid(axi_rid),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
        .inst(inst), .inst_err(inst_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: the two words of the single-fetch scenario, hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        if (a == 64'h8000_0000) return 32'h0000_0413;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        lo = a[31:0];
        return (lo * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic int pick(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(0, 3));
    endfunction

    // reference model: the one fetch in flight
    bit          pend = 0, killed = 0;
    logic [63:0] e_pc = '0;
    logic [7:0]  e_len = '0;
    logic [1:0]  e_size = '0;
    logic        e_resp1 = 1'b0;
    int          cyc = 0, t_req = 0, t_ar = -1, t_val = -1;
    bit          req_fired = 0;
    int          n_deliv = 0, n_vis = 0;
    logic [31:0] last_inst = '0;
    logic        last_err = 1'b0;
    // slave / decode knobs and state
    int          ar_wait_fix = 0, r_wait_fix = 0, resp_force = 0, dec_hold = 0;
    bit          rnd = 0;
    bit          ar_live = 0, first_beat = 0;
    int          ar_cnt = 0, ar_need = 0, beats_left = 0, r_cnt = 0, r_need = 0;
    logic [63:0] baddr = '0;
    logic [1:0]  first_resp = '0;
    // stability tracking
    bit          prev_ar_wait = 0, prev_hold = 0;
    logic [63:0] hold_pc = '0;
    logic [33:0] hold_w = '0;

    // One clock cycle: drive slave/decode side, sample mid-cycle, check, update.
    task automatic step();
        bit q_f, ar_f, r_f, i_f;
        if (axi_arvalid && !ar_live) begin
            ar_live = 1; ar_cnt = 0; ar_need = pick(ar_wait_fix);
        end
        axi_arready = axi_arvalid && (ar_cnt >= ar_need);
        if (beats_left > 0 && r_cnt >= r_need) begin
            axi_rvalid = 1'b1;
            axi_rdata  = {mem_word(baddr + 64'd4), mem_word(baddr)};
            axi_rresp  = first_beat ? first_resp : 2'($urandom_range(0, 3));
            axi_rlast  = (beats_left == 1);
            axi_rid    = 4'($urandom_range(0, 15));
        end else begin
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
            axi_rdata  = {$urandom, $urandom};
        end
        if (rnd) inst_ready = ($urandom_range(0, 2) != 0);
        else     inst_ready = !(dec_hold > 0 && inst_valid);
        if (flush) inst_ready = 1'b0;
        #1;
        q_f  = req_valid && req_ready;
        ar_f = axi_arvalid && axi_arready;
        r_f  = axi_rvalid && axi_rready;
        i_f  = inst_valid && inst_ready;

        if (flush) chk("rdy_in_flush", req_ready, 0);
        if (prev_ar_wait) chk("ar_hold", axi_arvalid, 1);
        if (prev_hold) begin
            chk("hold_pc", inst_pc, hold_pc);
            chk("hold_inst", {inst_valid, inst_err, inst}, hold_w);
        end
        if (inst_valid && !inst_ready && !flush) chk("rdy_stall", req_ready, 0);
        if (axi_arvalid) begin
            chk("ar_pend", pend, 1);
            if (pend) begin
                chk("araddr", axi_araddr, e_pc);
                chk("ar_ctl", {axi_arid, axi_arburst, axi_arsize, axi_arlen},
                    {4'h0, 2'b01, 1'b0, e_size, e_len});
            end
            if (t_ar < 0) t_ar = cyc;
        end
        if (inst_valid) begin
            n_vis++;
            if (t_val < 0) t_val = cyc;
            chk("inst_live", pend && !killed, 1);
            if (i_f && pend && !killed) begin
                chk("inst_pc", inst_pc, e_pc);
                chk("inst", inst, mem_word({e_pc[63:2], 2'b00}));
                chk("inst_err", inst_err, e_resp1 | (e_pc[1:0] != 2'b00));
                last_inst = inst; last_err = inst_err;
                n_deliv++;
            end
        end

        if (flush && pend) killed = 1;
        if (i_f) pend = 0;
        if (q_f) begin
            pend = 1; killed = 0; e_pc = req_addr; e_len = req_len; e_size = req_size;
            e_resp1 = 1'b0; t_req = cyc; t_ar = -1; t_val = -1;
        end
        req_fired = q_f;

        if (ar_f) begin
            ar_live = 0;
            beats_left = int'(axi_arlen) + 1;
            baddr = {axi_araddr[63:3], 3'b000};
            first_beat = 1;
            if (resp_force >= 0) first_resp = 2'(resp_force);
            else first_resp = ($urandom_range(0, 7) == 0) ? 2'b10 :
                              (($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
            r_cnt = 0; r_need = pick(r_wait_fix);
        end else if (axi_arvalid) begin
            ar_cnt++;
        end
        if (r_f) begin
            if (first_beat) e_resp1 = axi_rresp[1];
            first_beat = 0; beats_left--; baddr += 64'd8;
            r_cnt = 0; r_need = pick(r_wait_fix);
        end else if (beats_left > 0) begin
            r_cnt++;
        end

        prev_ar_wait = axi_arvalid && !axi_arready;
        prev_hold = inst_valid && !inst_ready && !flush;
        hold_pc = inst_pc;
        hold_w = {inst_valid, inst_err, inst};
        if (inst_valid && !inst_ready && dec_hold > 0) dec_hold--;
        cyc++;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [63:0] a);
        int n;
        req_valid = 1'b1; req_addr = a; req_len = 8'd0; req_size = 2'd2;
        n = 0;
        do begin step(); n++; end while (!req_fired && n < 50);
        chk("req_accept_to", req_fired, 1);
        req_valid = 1'b0;
        n = 0;
        while (pend && n < 60) begin step(); n++; end
        chk("inst_to", pend, 0);
    endtask

    task automatic issue_until_r(input logic [63:0] a);
        int n;
        req_valid = 1'b1; req_addr = a; req_len = 8'd1; req_size = 2'd3;
        n = 0;
        do begin step(); n++; end while (!req_fired && n < 50);
        req_valid = 1'b0;
        n = 0;
        while (!axi_rready && n < 30) begin step(); n++; end
        chk("reach_r", axi_rready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v0;
        bit done;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_hs", {axi_arvalid, axi_rready, inst_valid}, 3'b000);
        chk("rst_out", {inst_err, inst, inst_pc}, '0);
        reset_n = 1'b1;
        #1 chk("rst_rdy", req_ready, 1);
        @(negedge clk);

        // single fetch, minimum latency
        fetch(64'h8000_0000);
        chk("lat_ar", 64'(t_ar - t_req), 1);
        chk("lat_valid", 64'(t_val - t_req), 3);
        chk("lo_word", last_inst, 32'h0000_0413);
        // upper word
        fetch(64'h8000_0004);
        chk("hi_word", last_inst, 32'h0010_0093);

        // backpressure on AR and decode
        ar_wait_fix = 5; dec_hold = 4;
        fetch(64'h8000_0008);
        chk("lat_bp", 64'(t_val - t_req), 8);
        ar_wait_fix = 0;

        // flush while waiting in R
        r_wait_fix = 4;
        issue_until_r(64'h8000_0010);
        v0 = n_vis;
        flush = 1'b1; step(); flush = 1'b0;
        n = 0;
        while ((beats_left > 0 || axi_rready) && n < 40) begin step(); n++; end
        repeat (2) step();
        chk("flush_drain", axi_rready, 0);
        chk("flush_vis", 64'(n_vis - v0), 0);
        r_wait_fix = 0;
        fetch(64'h8000_0100);
        chk("after_flush", last_inst, mem_word(64'h8000_0100));

        // bus error and misalignment
        resp_force = 2;
        fetch(64'h8000_0018);
        chk("slverr", last_err, 1);
        resp_force = 0;
        fetch(64'h8000_0002);
        chk("misalign", last_err, 1);
        fetch(64'h8000_001C);
        chk("okay_err", last_err, 0);

        // async reset in R
        r_wait_fix = 6;
        issue_until_r(64'h8000_0020);
        #2 reset_n = 1'b0;
        #1 chk("async_rst", {axi_arvalid, axi_rready, inst_valid}, 3'b000);
        pend = 0; killed = 0; beats_left = 0; ar_live = 0; first_beat = 0;
        prev_ar_wait = 0; prev_hold = 0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0; req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst", {req_ready, axi_arvalid, axi_rready, inst_valid}, 4'b1000);
        @(negedge clk);
        r_wait_fix = 0;
        fetch(64'h8000_0028);

        // random run
        rnd = 1; ar_wait_fix = -1; r_wait_fix = -1; resp_force = -1;
        for (int i = 0; i < 3000; i++) begin
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_addr = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4
                         + (($urandom_range(0, 15) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
                req_len  = 8'($urandom_range(0, 3));
                req_size = 2'($urandom_range(0, 3));
            end
            flush = ($urandom_range(0, 24) == 0);
            step();
            if (req_fired) req_valid = 1'b0;
        end
        rnd = 0; flush = 1'b0; dec_hold = 0; req_valid = 1'b0;
        n = 0; done = 0;
        while (!done && n < 100) begin
            step(); n++;
            done = (!pend || killed) && beats_left == 0 && !axi_arvalid && !inst_valid;
        end
        chk("drain", done, 1);
        chk("delivered", n_deliv > 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_ifu_axi.md
Name: ysyx_22041071_ifu_axi

Overview:
Instruction-fetch AXI read master, directly downstream of the PC stage. Accepts one fetch request (address, len, size) per handshake from the PC stage and issues it on the AXI4 AR channel. Collects R beats, extracts the 32-bit instruction for the fetched PC and presents {pc, inst, err} to decode over a valid/ready interface. One outstanding transaction at a time; supports a redirect flush.

Parameters:
ADDR_W, 64, address width (PC, araddr)
DATA_W, 64, AXI read data width
ID_W, 4, AXI ID width
AXI_ID, 0, constant arid value for fetches

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid from PC stage (its cpu_if_ar_valid)
req_addr  in  ADDR_W  fetch address (cpu_addr)
req_len  in  8  AXI len from PC stage (cpu_len)
req_size  in  2  size code from PC stage (cpu_size)
req_ready  out  1  request accepted; drives PC-stage ready1
flush  in  1  redirect; discard in-flight/held fetch
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_araddr  out  ADDR_W  AR address
axi_arid  out  ID_W  AR id
axi_arlen  out  8  AR len
axi_arsize  out  3  AR size = {1'b0, req_size}
axi_arburst  out  2  constant 2'b01 (INCR)
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready
axi_rdata  in  DATA_W  R data
axi_rresp  in  2  R response
axi_rlast  in  1  R last
axi_rid  in  ID_W  R id
inst_valid  out  1  instruction valid to decode
inst_ready  in  1  decode ready
inst_pc  out  ADDR_W  PC of instruction
inst  out  32  instruction word
inst_err  out  1  bus error on fetch (rresp[1] of first beat)

Behaviour:
- FSM states: IDLE, AR, R, OUT. Reset (async, reset_n=0): state IDLE, axi_arvalid=0, axi_rready=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0, drop flag=0; req_ready=1 once reset_n released.
- req_ready is combinational: 1 in IDLE, and 1 in OUT when inst_ready=1 && !flush. Handshake req_valid&&req_ready latches addr/len/size -> AR next cycle (back-to-back, 1-cycle request-to-arvalid latency).
- AR: axi_arvalid=1 with latched fields stable until axi_arready; on arvalid&&arready -> R. arvalid never withdrawn before handshake.
- R: axi_rready=1. The first beat's rdata/rresp is latched; later beats (len>0) are consumed and discarded. On rvalid&&rlast -> OUT (or IDLE if drop flag set; drop flag cleared). rid not checked.
- OUT: inst_valid=1; inst = inst_pc[2] ? rdata[63:32] : rdata[31:0]; inst_err = rresp[1]. inst_valid&&inst_ready -> IDLE, or -> AR if a new request is accepted in the same cycle. Outputs are held stable while inst_ready=0.
- flush: IDLE: no effect. AR or R: set drop flag; the transaction completes on AXI, its data is never presented. OUT: inst_valid deasserts next cycle -> IDLE. A request is never accepted in the flush cycle. flush together with rlast in R: the data is dropped.
- Minimum latency req handshake -> inst_valid: 3 cycles (arready and rvalid both immediate).
- Misaligned req_addr[1:0]!=0: fetch proceeds; inst_err forced to 1.

Optional Feature:
Macro YSYX_22041071_IFU_PERF_EN. When defined, adds outputs perf_fetch_cnt[63:0] (incremented per inst_valid&&inst_ready), perf_stall_cnt[63:0] (cycles in AR or R) and perf_flush_cnt[31:0] (flush asserted outside IDLE); all counters reset to 0 and wrap. When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Shared define file gets: FSM state encodings, INCR burst constant, AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), SIZE_D and the AXI len width, all reused by the data-side master.
- One natural sub-module: ysyx_22041071_ifu_axi_rbuf (first-beat capture, word select, output hold register).

Test Plan:
- Single fetch: req addr 0x80000000, arready/rvalid immediate, rdata 0x00100093_00000413 -> arvalid one cycle after req, inst_valid 3 cycles after req, inst=0x00000413, pc=0x80000000, err=0.
- Upper word: addr 0x80000004, same rdata -> inst=0x00100093.
- Backpressure: arready delayed 5 cycles, inst_ready low 4 cycles -> araddr/inst stable throughout, req_ready=0 until inst_ready.
- Flush in R: flush during wait for rvalid -> transaction completes, inst_valid never asserts, next req 0x80000100 is fetched normally.
- Error: rresp=2'b10 -> inst_err=1; misaligned addr 0x80000002 -> inst_err=1.
- Async reset mid-R: reset_n low -> arvalid, rready and inst_valid are 0 immediately with no clock edge; state is IDLE after release.
